// File: rtl/ct_mmu_iutlb_refill.sv
// 32-entry fully associative instruction micro-TLB with JTLB refill FSM.
// Lookup result is registered; misses stall the IFU until the JTLB answers.
module ct_mmu_iutlb_refill (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ifu_mmu_req_vld,
    input  logic [26:0] ifu_mmu_req_vpn,
    output logic        mmu_ifu_hit,
    output logic [27:0] mmu_ifu_ppn,
    output logic        mmu_ifu_fault,
    output logic        mmu_ifu_stall,
    output logic        utlb_jtlb_req,
    output logic [26:0] utlb_jtlb_vpn,
    input  logic        jtlb_utlb_ack,
    input  logic [27:0] jtlb_utlb_ppn,
    input  logic        jtlb_utlb_fault,
    input  logic        cp0_mmu_tlb_flush,
    input  logic [31:0] plru_iutlb_ref_num,
    output logic [31:0] utlb_plru_read_hit,
    output logic        utlb_plru_read_hit_vld,
    output logic        utlb_plru_refill_on,
    output logic        utlb_plru_refill_vld,
    output logic        entry0_vld,
    output logic        entry1_vld,
    output logic        entry2_vld,
    output logic        entry3_vld,
    output logic        entry4_vld,
    output logic        entry5_vld,
    output logic        entry6_vld,
    output logic        entry7_vld,
    output logic        entry8_vld,
    output logic        entry9_vld,
    output logic        entry10_vld,
    output logic        entry11_vld,
    output logic        entry12_vld,
    output logic        entry13_vld,
    output logic        entry14_vld,
    output logic        entry15_vld,
    output logic        entry16_vld,
    output logic        entry17_vld,
    output logic        entry18_vld,
    output logic        entry19_vld,
    output logic        entry20_vld,
    output logic        entry21_vld,
    output logic        entry22_vld,
    output logic        entry23_vld,
    output logic        entry24_vld,
    output logic        entry25_vld,
    output logic        entry26_vld,
    output logic        entry27_vld,
    output logic        entry28_vld,
    output logic        entry29_vld,
    output logic        entry30_vld,
    output logic        entry31_vld
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MISS = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] vld_q, vld_d;
    logic        kill_q, kill_d;
    logic        hit_q, hit_d;
    logic [27:0] rppn_q, rppn_d;
    logic [31:0] rhit_q, rhit_d;
    logic        fault_q, fault_d;
    logic [26:0] vpn_q;
    logic [27:0] ppn_q;
    logic [4:0]  idx_q;
    logic [26:0] tag_q [32];
    logic [27:0] pte_q [32];

    logic [31:0] match;
    logic [4:0]  hit_idx;
    logic [4:0]  vic_idx;
    logic        lookup;
    logic        miss_go;
    logic        wr;

    assign lookup = (state_q == IDLE) && ifu_mmu_req_vld;

    // Lowest-index priority on tag match and on non-one-hot victim select.
    always_comb begin
        match   = '0;
        hit_idx = '0;
        vic_idx = '0;
        for (int i = 0; i < 32; i++) begin
            match[i] = vld_q[i] && (tag_q[i] == ifu_mmu_req_vpn);
        end
        for (int i = 31; i >= 0; i--) begin
            if (match[i]) hit_idx = 5'(i);
            if (plru_iutlb_ref_num[i]) vic_idx = 5'(i);
        end
    end

    // A flush coinciding with a lookup forces a miss.
    always_comb begin
        hit_d   = lookup && (|match) && !cp0_mmu_tlb_flush;
        miss_go = lookup && !hit_d;
        rhit_d  = hit_d ? (32'd1 << hit_idx) : '0;
        rppn_d  = hit_d ? pte_q[hit_idx] : '0;
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        fault_d = 1'b0;
        vld_d   = vld_q;
        wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_go) state_d = MISS;
            end
            MISS: begin
                if (cp0_mmu_tlb_flush) kill_d = 1'b1;
                if (jtlb_utlb_ack) begin
                    kill_d = 1'b0;
                    if (kill_q || cp0_mmu_tlb_flush) begin
                        state_d = IDLE;
                    end else if (jtlb_utlb_fault) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                wr = !cp0_mmu_tlb_flush;
                if (wr) vld_d[idx_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cp0_mmu_tlb_flush) vld_d = '0;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            vld_q   <= '0;
            kill_q  <= 1'b0;
            hit_q   <= 1'b0;
            rppn_q  <= '0;
            rhit_q  <= '0;
            fault_q <= 1'b0;
            vpn_q   <= '0;
            ppn_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            kill_q  <= kill_d;
            hit_q   <= hit_d;
            rppn_q  <= rppn_d;
            rhit_q  <= rhit_d;
            fault_q <= fault_d;
            if (miss_go) vpn_q <= ifu_mmu_req_vpn;
            if (state_q == MISS && jtlb_utlb_ack) begin
                ppn_q <= jtlb_utlb_ppn;
                idx_q <= vic_idx;
            end
        end
    end

    // Tag and PPN storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge forever_cpuclk) begin
        if (wr) begin
            tag_q[idx_q] <= vpn_q;
            pte_q[idx_q] <= ppn_q;
        end
    end

    assign mmu_ifu_hit            = hit_q;
    assign mmu_ifu_ppn            = rppn_q;
    assign mmu_ifu_fault          = fault_q;
    assign mmu_ifu_stall          = (state_q != IDLE);
    assign utlb_jtlb_req          = (state_q == MISS);
    assign utlb_jtlb_vpn          = vpn_q;
    assign utlb_plru_read_hit     = rhit_q;
    assign utlb_plru_read_hit_vld = hit_q;
    assign utlb_plru_refill_on    = (state_q == MISS) || (state_q == FILL);
    assign utlb_plru_refill_vld   = (state_q == FILL) && !cp0_mmu_tlb_flush;

    assign entry0_vld  = vld_q[0];
    assign entry1_vld  = vld_q[1];
    assign entry2_vld  = vld_q[2];
    assign entry3_vld  = vld_q[3];
    assign entry4_vld  = vld_q[4];
    assign entry5_vld  = vld_q[5];
    assign entry6_vld  = vld_q[6];
    assign entry7_vld  = vld_q[7];
    assign entry8_vld  = vld_q[8];
    assign entry9_vld  = vld_q[9];
    assign entry10_vld = vld_q[10];
    assign entry11_vld = vld_q[11];
    assign entry12_vld = vld_q[12];
    assign entry13_vld = vld_q[13];
    assign entry14_vld = vld_q[14];
    assign entry15_vld = vld_q[15];
    assign entry16_vld = vld_q[16];
    assign entry17_vld = vld_q[17];
    assign entry18_vld = vld_q[18];
    assign entry19_vld = vld_q[19];
    assign entry20_vld = vld_q[20];
    assign entry21_vld = vld_q[21];
    assign entry22_vld = vld_q[22];
    assign entry23_vld = vld_q[23];
    assign entry24_vld = vld_q[24];
    assign entry25_vld = vld_q[25];
    assign entry26_vld = vld_q[26];
    assign entry27_vld = vld_q[27];
    assign entry28_vld = vld_q[28];
    assign entry29_vld = vld_q[29];
    assign entry30_vld = vld_q[30];
    assign entry31_vld = vld_q[31];

endmodule

// File: doc/ct_mmu_iutlb_refill.md
CT_MMU_IUTLB_REFILL -- requirements
Module: ct_mmu_iutlb_refill

Interface
REQ-001 SHALL have port forever_cpuclk  in  1  sole clock; all state on its rising edge.
REQ-002 SHALL have port cpurst_b  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port ifu_mmu_req_vld  in  1  fetch translation request valid.
REQ-004 SHALL have port ifu_mmu_req_vpn  in  27  request virtual page number.
REQ-005 SHALL have port mmu_ifu_hit  out  1  registered hit response, one-cycle pulse.
REQ-006 SHALL have port mmu_ifu_ppn  out  28  PPN of hit entry, valid with mmu_ifu_hit.
REQ-007 SHALL have port mmu_ifu_fault  out  1  one-cycle pulse, JTLB refill faulted.
REQ-008 SHALL have port mmu_ifu_stall  out  1  high whenever FSM is not IDLE.
REQ-009 SHALL have port utlb_jtlb_req  out  1  refill request, held until ack.
REQ-010 SHALL have port utlb_jtlb_vpn  out  27  missing VPN, stable while utlb_jtlb_req.
REQ-011 SHALL have port jtlb_utlb_ack  in  1  refill response valid, one cycle.
REQ-012 SHALL have port jtlb_utlb_ppn  in  28  refill PPN, valid with ack.
REQ-013 SHALL have port jtlb_utlb_fault  in  1  refill fault, valid with ack.
REQ-014 SHALL have port cp0_mmu_tlb_flush  in  1  invalidate all entries, one-cycle pulse.
REQ-015 SHALL have port plru_iutlb_ref_num  in  32  PLRU victim, one-hot.
REQ-016 SHALL have port utlb_plru_read_hit  out  32  one-hot hit entry, valid with read_hit_vld.
REQ-017 SHALL have port utlb_plru_read_hit_vld  out  1  hit update pulse to PLRU.
REQ-018 SHALL have port utlb_plru_refill_on  out  1  high in MISS and FILL.
REQ-019 SHALL have port utlb_plru_refill_vld  out  1  one-cycle pulse in FILL when an entry is written.
REQ-020 SHALL have ports entry0_vld .. entry31_vld  out  1 each  entry valid bits.

Function
REQ-021 SHALL hold 32 entries, each with valid bit, 27-bit VPN tag and 28-bit PPN.
REQ-022 SHALL use FSM states IDLE, MISS and FILL.
REQ-023 SHALL, in IDLE with ifu_mmu_req_vld at cycle T, compare the VPN against all valid tags and register the result.
REQ-024 SHALL, on a hit at T, drive mmu_ifu_hit=1, mmu_ifu_ppn, utlb_plru_read_hit (one-hot) and read_hit_vld=1 at T+1 only.
REQ-025 SHALL, on multiple tag matches, select the lowest index.
REQ-026 SHALL, on a miss at T, latch the VPN and enter MISS at T+1 with utlb_jtlb_req=1 and utlb_jtlb_vpn=latched VPN.
REQ-027 SHALL hold utlb_jtlb_req and utlb_jtlb_vpn in MISS until jtlb_utlb_ack; the request drops in the cycle after ack.
REQ-028 SHALL, on ack with fault=0 and no pending kill, latch PPN and plru_iutlb_ref_num, then enter FILL.
REQ-029 SHALL, in FILL, write the VPN/PPN into the entry selected by the latched ref_num and set its valid bit (visible next cycle), pulse refill_vld, then return to IDLE.
REQ-030 SHALL use the lowest set bit when ref_num is not one-hot, and entry 0 when ref_num is zero.
REQ-031 SHALL, on ack with fault=1, write nothing, pulse mmu_ifu_fault the next cycle and return to IDLE.
REQ-032 SHALL ignore ifu_mmu_req_vld outside IDLE (no hit, no update); the IFU replays.
REQ-033 SHALL, on cp0_mmu_tlb_flush, clear all 32 valid bits at the next edge, in any state.
REQ-034 SHALL, on flush in MISS, set a kill flag; the ack is consumed, nothing is written, no fault pulse is given, and the FSM returns to IDLE.
REQ-035 SHALL, on flush in FILL, suppress the write and the refill_vld pulse, and clear valid; flush wins.
REQ-036 SHALL, when a flush coincides with an IDLE lookup, report a miss if the lookup would otherwise hit.
REQ-037 SHALL, on ack in the same cycle utlb_jtlb_req first rises, accept it normally.

Reset
REQ-038 SHALL, with cpurst_b low, asynchronously force FSM=IDLE, all valid bits=0, kill=0, and all outputs=0 (tags/PPN need no reset).
REQ-039 SHALL, on reset mid-refill, drop the request immediately; an ack arriving after reset release in IDLE is ignored.

Verification
REQ-040 SHALL cover: after reset, request VPN 0x12345 -> miss; utlb_jtlb_req=1 vpn=0x12345 from T+1; ack ppn=0xABCDE, ref_num=0x4 -> refill_vld pulse, entry2_vld=1.
REQ-041 SHALL cover: replay VPN 0x12345 -> mmu_ifu_hit=1, ppn=0xABCDE, read_hit=0x00000004, read_hit_vld=1 at T+1.
REQ-042 SHALL cover: miss then ack with fault=1 -> mmu_ifu_fault pulse, all entryN_vld unchanged, stall drops.
REQ-043 SHALL cover: flush asserted while in MISS, then ack -> no write, all valid=0, no refill_vld pulse, no fault pulse, FSM IDLE.
REQ-044 SHALL cover: fill all 32 entries using ref_num 1<<n, flush -> all 32 entryN_vld=0 next cycle; any lookup misses.
REQ-045 SHALL cover: cpurst_b low during MISS -> utlb_jtlb_req=0 immediately; a later ack is ignored, no entry written.
